// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_pkg: shared types and encodings for the multicycle datapath        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    ADDIEX  = 4'd8,
    ADDIWB  = 4'd9,
    BEQEX   = 4'd10,
    JEX     = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  function automatic logic funct_legal(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl_fsm: main control FSM, stalls in place while memory not ready |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output state_t     state_o,
  output logic       irwrite_o,
  output logic       pcwrite_o,
  output logic       abwrite_o,
  output logic       aluoutwrite_o,
  output logic       mdrwrite_o,
  output logic       regwrite_o,
  output logic       retire_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       iord_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsrc_o,
  output logic [2:0] alucontrol_o,
  output logic       mem_req_o,
  output logic       mem_we_o
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d       = state_q;
    irwrite_o     = 1'b0;
    pcwrite_o     = 1'b0;
    abwrite_o     = 1'b0;
    aluoutwrite_o = 1'b0;
    mdrwrite_o    = 1'b0;
    regwrite_o    = 1'b0;
    retire_o      = 1'b0;
    regdst_o      = 1'b0;
    memtoreg_o    = 1'b0;
    iord_o        = 1'b0;
    alusrca_o     = 1'b0;
    alusrcb_o     = SRCB_B;
    pcsrc_o       = PC_ALU;
    alucontrol_o  = ALU_ADD;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_o = 1'b1;
        alusrcb_o = SRCB_FOUR;
        if (mem_ready_i) begin
          irwrite_o = 1'b1;
          pcwrite_o = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        // pc already points past this instruction, so this is the beq target
        abwrite_o     = 1'b1;
        aluoutwrite_o = 1'b1;
        alusrcb_o     = SRCB_IMMSH;
        case (opcode_i)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = funct_legal(funct_i) ? RTYPEEX : HALT;
          OP_ADDI:      state_d = ADDIEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
          default:      state_d = HALT;
        endcase
      end
      MEMADR: begin
        alusrca_o     = 1'b1;
        alusrcb_o     = SRCB_IMM;
        aluoutwrite_o = 1'b1;
        state_d       = (opcode_i == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          mdrwrite_o = 1'b1;
          state_d    = MEMWB;
        end
      end
      MEMWB: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
        retire_o   = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          state_d  = FETCH;
        end
      end
      RTYPEEX: begin
        alusrca_o     = 1'b1;
        alucontrol_o  = funct_alu(funct_i);
        aluoutwrite_o = 1'b1;
        state_d       = ALUWB;
      end
      ALUWB: begin
        regwrite_o = 1'b1;
        regdst_o   = 1'b1;
        retire_o   = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        alusrca_o     = 1'b1;
        alusrcb_o     = SRCB_IMM;
        aluoutwrite_o = 1'b1;
        state_d       = ADDIWB;
      end
      ADDIWB: begin
        regwrite_o = 1'b1;
        retire_o   = 1'b1;
        state_d    = FETCH;
      end
      BEQEX: begin
        alusrca_o    = 1'b1;
        alucontrol_o = ALU_SUB;
        pcsrc_o      = PC_ALUOUT;
        pcwrite_o    = zero_i;
        retire_o     = 1'b1;
        state_d      = FETCH;
      end
      JEX: begin
        pcsrc_o   = PC_JUMP;
        pcwrite_o = 1'b1;
        retire_o  = 1'b1;
        state_d   = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_datapath: multicycle core, shared req/ready memory port            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mc_datapath
  import mc_pkg::*;
#(
  parameter int          N        = 32,
  parameter int          REGS     = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         halted,
  output logic [N-1:0] instret,
  output logic [N-1:0] pc
);

  localparam int           RW         = (REGS > 1) ? $clog2(REGS) : 1;
  localparam logic [N-1:0] C_RESET_PC = N'(RESET_PC);

  state_t     state;
  logic       irwrite, pcwrite, abwrite, aluoutwrite, mdrwrite;
  logic       regwrite, retire, regdst, memtoreg, iord, alusrca;
  logic       fsm_req, fsm_we, zero;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  logic [N-1:0]  pc_q, pc_d;
  logic [31:0]   ir_q;
  logic [N-1:0]  a_q, b_q, aluout_q, mdr_q, instret_q;
  logic [N-1:0]  rf_q [REGS];

  logic [N-1:0]  signimm, srca, srcb, alu_y, rd1, rd2, wdata;
  logic [RW-1:0] rs, rt, rd, waddr;

  mc_ctrl_fsm u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .opcode_i     (ir_q[31:26]),
    .funct_i      (ir_q[5:0]),
    .mem_ready_i  (mem_ready),
    .zero_i       (zero),
    .state_o      (state),
    .irwrite_o    (irwrite),
    .pcwrite_o    (pcwrite),
    .abwrite_o    (abwrite),
    .aluoutwrite_o(aluoutwrite),
    .mdrwrite_o   (mdrwrite),
    .regwrite_o   (regwrite),
    .retire_o     (retire),
    .regdst_o     (regdst),
    .memtoreg_o   (memtoreg),
    .iord_o       (iord),
    .alusrca_o    (alusrca),
    .alusrcb_o    (alusrcb),
    .pcsrc_o      (pcsrc),
    .alucontrol_o (alucontrol),
    .mem_req_o    (fsm_req),
    .mem_we_o     (fsm_we)
  );

  // Narrow register files simply drop the upper index bits
  assign rs      = ir_q[21 +: RW];
  assign rt      = ir_q[16 +: RW];
  assign rd      = ir_q[11 +: RW];
  assign signimm = {{(N-16){ir_q[15]}}, ir_q[15:0]};
  assign rd1     = (rs == '0) ? '0 : rf_q[rs];
  assign rd2     = (rt == '0) ? '0 : rf_q[rt];
  assign waddr   = regdst ? rd : rt;
  assign wdata   = memtoreg ? mdr_q : aluout_q;

  always_comb begin
    srca = alusrca ? a_q : pc_q;
    case (alusrcb)
      SRCB_B:    srcb = b_q;
      SRCB_FOUR: srcb = {{(N-3){1'b0}}, 3'b100};
      SRCB_IMM:  srcb = signimm;
      default:   srcb = {signimm[N-3:0], 2'b00};
    endcase
    case (alucontrol)
      ALU_SUB: alu_y = srca - srcb;
      ALU_AND: alu_y = srca & srcb;
      ALU_OR:  alu_y = srca | srcb;
      ALU_SLT: alu_y = {{(N-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: alu_y = srca + srcb;
    endcase
  end

  assign zero = (alu_y == '0);

  always_comb begin
    case (pcsrc)
      PC_ALUOUT: pc_d = aluout_q;
      PC_JUMP:   pc_d = {pc_q[N-1:28], ir_q[25:0], 2'b00};
      default:   pc_d = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= C_RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      instret_q <= '0;
    end else begin
      if (pcwrite)     pc_q      <= pc_d;
      if (irwrite)     ir_q      <= mem_rdata[31:0];
      if (abwrite)     a_q       <= rd1;
      if (abwrite)     b_q       <= rd2;
      if (aluoutwrite) aluout_q  <= alu_y;
      if (mdrwrite)    mdr_q     <= mem_rdata;
      if (retire)      instret_q <= instret_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else if (regwrite && (waddr != '0)) begin
      rf_q[waddr] <= wdata;
    end
  end

  // Reset masks the request so an in-flight transaction is abandoned at once
  assign mem_req   = rst & fsm_req;
  assign mem_we    = fsm_we;
  assign mem_addr  = iord ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign halted    = (state == HALT);
  assign instret   = instret_q;
  assign pc        = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_datapath: directed self-checking bench for mc_datapath          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mc_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst8;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instret, pc;
  logic        mem_req8, mem_we8, mem_ready8, halted8;
  logic [31:0] mem_addr8, mem_wdata8, mem_rdata8, instret8, pc8;

  logic [31:0] mem  [64];
  logic [31:0] mem8 [64];
  int wait_n = 0;
  int wcnt   = 0;
  int n_checks = 0;
  int n_pass   = 0;

  mc_datapath #(.N(32), .REGS(32), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .instret(instret), .pc(pc)
  );

  mc_datapath #(.N(32), .REGS(8), .RESET_PC(0)) dut8 (
    .clk(clk), .rst(rst8), .mem_req(mem_req8), .mem_we(mem_we8),
    .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .mem_rdata(mem_rdata8),
    .mem_ready(mem_ready8), .halted(halted8), .instret(instret8), .pc(pc8)
  );

  // Memory models: main one inserts wait_n wait cycles per transaction
  assign mem_ready  = mem_req && (wcnt == wait_n);
  assign mem_rdata  = mem[mem_addr[7:2]];
  assign mem_ready8 = mem_req8;
  assign mem_rdata8 = mem8[mem_addr8[7:2]];

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (mem_req && mem_ready && mem_we) mem[mem_addr[7:2]] = mem_wdata;
    if (mem_req8 && mem_we8) mem8[mem_addr8[7:2]] = mem_wdata8;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5A5A5;
    tick();
  endtask

  task automatic test_reset();
    hold_reset();
    mem[0] = 32'h20020005;   // addi $2,$0,5
    mem[1] = 32'hAC020048;   // sw   $2,0x48($0)
    mem[2] = 32'h08000002;   // j    8
    tick();
    n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); else n_pass++;
    n_checks++; if (instret !== 32'h0) $display("FAIL reset_instret: got %h expected %h", instret, 32'h0); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", mem_req); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL first_req: got %b expected 1", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL first_addr: got %h expected %h", mem_addr, 32'h0); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL first_we: got %b expected 0", mem_we); else n_pass++;
    ticks(3);
    n_checks++; if (instret !== 32'd0) $display("FAIL addi_early: got %0d expected 0", instret); else n_pass++;
    tick();
    n_checks++; if (instret !== 32'd1) $display("FAIL addi_instret: got %0d expected 1", instret); else n_pass++;
    n_checks++; if (pc !== 32'd4) $display("FAIL addi_pc: got %h expected %h", pc, 32'd4); else n_pass++;
    ticks(4);
    n_checks++; if (mem[18] !== 32'd5) $display("FAIL addi_rf2: got %h expected %h", mem[18], 32'd5); else n_pass++;
    n_checks++; if (instret !== 32'd2) $display("FAIL sw_instret: got %0d expected 2", instret); else n_pass++;
  endtask

  task automatic test_alu();
    hold_reset();
    mem[0]  = 32'h20020005;  // addi $2,$0,5
    mem[1]  = 32'h2003FFFD;  // addi $3,$0,-3
    mem[2]  = 32'h00432822;  // sub  $5,$2,$3
    mem[3]  = 32'h00433024;  // and  $6,$2,$3
    mem[4]  = 32'h00433825;  // or   $7,$2,$3
    mem[5]  = 32'h0062402A;  // slt  $8,$3,$2
    mem[6]  = 32'h0043482A;  // slt  $9,$2,$3
    mem[7]  = 32'hAC050080;  // sw   $5,0x80
    mem[8]  = 32'hAC060084;  // sw   $6,0x84
    mem[9]  = 32'hAC070088;  // sw   $7,0x88
    mem[10] = 32'hAC08008C;  // sw   $8,0x8C
    mem[11] = 32'hAC090090;  // sw   $9,0x90
    mem[12] = 32'h10430001;  // beq  $2,$3,+1 (not taken)
    mem[13] = 32'h0800000D;  // j    52
    rst = 1'b1;
    ticks(60);
    n_checks++; if (mem[32] !== 32'd8) $display("FAIL alu_sub: got %h expected %h", mem[32], 32'd8); else n_pass++;
    n_checks++; if (mem[33] !== 32'd5) $display("FAIL alu_and: got %h expected %h", mem[33], 32'd5); else n_pass++;
    n_checks++; if (mem[34] !== 32'hFFFFFFFD) $display("FAIL alu_or: got %h expected %h", mem[34], 32'hFFFFFFFD); else n_pass++;
    n_checks++; if (mem[35] !== 32'd1) $display("FAIL alu_slt_true: got %h expected %h", mem[35], 32'd1); else n_pass++;
    n_checks++; if (mem[36] !== 32'd0) $display("FAIL alu_slt_false: got %h expected %h", mem[36], 32'd0); else n_pass++;
    n_checks++; if (pc !== 32'd52) $display("FAIL beq_not_taken_pc: got %h expected %h", pc, 32'd52); else n_pass++;
    n_checks++; if (instret !== 32'd16) $display("FAIL alu_instret: got %0d expected 16", instret); else n_pass++;
  endtask

  task automatic test_lwsw_beq();
    hold_reset();
    mem[16] = 32'hDEADBEEF;
    mem[0]  = 32'h8C030040;  // lw  $3,0x40($0)
    mem[1]  = 32'hAC030044;  // sw  $3,0x44($0)
    mem[2]  = 32'h1000FFFF;  // beq $0,$0,-1
    rst = 1'b1;
    ticks(5);
    n_checks++; if (instret !== 32'd1) $display("FAIL lw_instret: got %0d expected 1", instret); else n_pass++;
    ticks(3);
    n_checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL sw_req_we: got %b expected 11", {mem_req, mem_we}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h44) $display("FAIL sw_addr: got %h expected %h", mem_addr, 32'h44); else n_pass++;
    n_checks++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h expected %h", mem_wdata, 32'hDEADBEEF); else n_pass++;
    tick();
    n_checks++; if (instret !== 32'd2) $display("FAIL lwsw_instret: got %0d expected 2", instret); else n_pass++;
    n_checks++; if (mem[17] !== 32'hDEADBEEF) $display("FAIL sw_mem: got %h expected %h", mem[17], 32'hDEADBEEF); else n_pass++;
    n_checks++; if (pc !== 32'd8) $display("FAIL pre_loop_pc: got %h expected %h", pc, 32'd8); else n_pass++;
    tick();
    n_checks++; if (pc !== 32'd12) $display("FAIL loop_fetch_pc: got %h expected %h", pc, 32'd12); else n_pass++;
    ticks(2);
    for (int k = 1; k <= 3; k++) begin
      n_checks++; if (pc !== 32'd8) $display("FAIL beq_loop_pc: got %h expected %h", pc, 32'd8); else n_pass++;
      n_checks++; if (instret !== 32'(2 + k)) $display("FAIL beq_loop_instret: got %0d expected %0d", instret, 2 + k); else n_pass++;
      ticks(3);
    end
  endtask

  task automatic test_wait_states();
    logic        prev_req, prev_ready;
    logic [31:0] prev_addr;
    hold_reset();
    wait_n = 3;
    mem[0] = 32'h20020005;   // addi $2,$0,5
    mem[1] = 32'h2003FFFD;   // addi $3,$0,-3
    mem[2] = 32'h00432020;   // add  $4,$2,$3
    mem[3] = 32'hAC040050;   // sw   $4,0x50($0)
    mem[4] = 32'h08000004;   // j    16
    rst = 1'b1;
    #1;
    prev_req   = mem_req;
    prev_ready = mem_ready;
    prev_addr  = mem_addr;
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (prev_req && !prev_ready && mem_req) begin
        n_checks++; if (mem_addr !== prev_addr) $display("FAIL wait_addr_stable: got %h expected %h", mem_addr, prev_addr); else n_pass++;
      end
      if (c == 20) begin
        n_checks++; if (instret !== 32'd2) $display("FAIL wait_add_early: got %0d expected 2", instret); else n_pass++;
      end
      if (c == 21) begin
        n_checks++; if (instret !== 32'd3) $display("FAIL wait_add_done: got %0d expected 3", instret); else n_pass++;
      end
      prev_req   = mem_req;
      prev_ready = mem_ready;
      prev_addr  = mem_addr;
    end
    n_checks++; if (mem[20] !== 32'd2) $display("FAIL wait_add_result: got %h expected %h", mem[20], 32'd2); else n_pass++;
    n_checks++; if (instret !== 32'd4) $display("FAIL wait_instret: got %0d expected 4", instret); else n_pass++;
    rst = 1'b0;
    wait_n = 0;
    tick();
  endtask

  task automatic test_halt();
    hold_reset();
    mem[0] = 32'h20020005;   // addi $2,$0,5
    mem[1] = 32'hFC000000;   // illegal opcode
    rst = 1'b1;
    ticks(5);
    n_checks++; if (halted !== 1'b0) $display("FAIL halt_early: got %b expected 0", halted); else n_pass++;
    tick();
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_set: got %b expected 1", halted); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (mem_req !== 1'b0) $display("FAIL halt_req: got %b expected 0", mem_req); else n_pass++;
    end
    n_checks++; if (pc !== 32'd8) $display("FAIL halt_pc: got %h expected %h", pc, 32'd8); else n_pass++;
    n_checks++; if (instret !== 32'd1) $display("FAIL halt_instret: got %0d expected 1", instret); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (halted !== 1'b0) $display("FAIL halt_clear: got %b expected 0", halted); else n_pass++;
    n_checks++; if (pc !== 32'd0) $display("FAIL halt_clear_pc: got %h expected %h", pc, 32'd0); else n_pass++;
    mem[0] = 32'h0000003F;   // R-type with illegal funct
    rst = 1'b1;
    ticks(2);
    n_checks++; if (halted !== 1'b1) $display("FAIL funct_halt: got %b expected 1", halted); else n_pass++;
    n_checks++; if (pc !== 32'd4) $display("FAIL funct_halt_pc: got %h expected %h", pc, 32'd4); else n_pass++;
  endtask

  task automatic test_regs8();
    for (int i = 0; i < 64; i++) mem8[i] = 32'hA5A5A5A5;
    mem8[0] = 32'h20090007;  // addi $9,$0,7 (index truncates to 1)
    mem8[1] = 32'hAC010080;  // sw   $1,0x80($0)
    mem8[2] = 32'h08000002;  // j    8
    rst8 = 1'b0;
    tick();
    rst8 = 1'b1;
    ticks(7);
    n_checks++; if (mem_addr8 !== 32'h80) $display("FAIL r8_sw_addr: got %h expected %h", mem_addr8, 32'h80); else n_pass++;
    tick();
    n_checks++; if (mem8[32] !== 32'd7) $display("FAIL r8_rf1: got %h expected %h", mem8[32], 32'd7); else n_pass++;
    n_checks++; if (instret8 !== 32'd2) $display("FAIL r8_instret: got %0d expected 2", instret8); else n_pass++;
    ticks(3);
    n_checks++; if (pc8 !== 32'd8) $display("FAIL r8_pc: got %h expected %h", pc8, 32'd8); else n_pass++;
    n_checks++; if (halted8 !== 1'b0) $display("FAIL r8_halted: got %b expected 0", halted8); else n_pass++;
  endtask

  initial begin
    rst  = 1'b0;
    rst8 = 1'b0;
    test_reset();
    test_alu();
    test_lwsw_beq();
    test_wait_states();
    test_halt();
    test_regs8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
